// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet framing constants, link-speed and transmit FSM types
package eth_pkg;
  localparam logic [7:0] ETH_PREAMBLE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  typedef enum logic [1:0] {SPEED_10 = 2'b00, SPEED_100 = 2'b01, SPEED_1000 = 2'b10} eth_speed_t;
  typedef enum logic [3:0] {
    ST_IDLE, ST_PREAMBLE, ST_SFD, ST_PAYLOAD, ST_PAD, ST_FCS, ST_IFG, ST_ERR, ST_DROP
  } tx_state_t;
endpackage

// File: rtl/crc32_byte.sv
// crc32_byte: one byte step of the reflected Ethernet CRC-32, no final inversion
module crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) crc_out = crc_out[0] ? (crc_out >> 1) ^ CRC32_POLY_REFL : crc_out >> 1;
  end
endmodule

// File: rtl/rgmii_mac_tx.sv
// rgmii_mac_tx: Ethernet MAC transmit framer feeding the RGMII MAC-side byte port
// Adds preamble/SFD, pad and FCS, enforces IFG, splits bytes into nibbles below 1000M.
module rgmii_mac_tx
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IFG_BYTES = 12,
  parameter int PREAMBLE_BYTES = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] link_speed,
  input  logic [7:0] s_tx_tdata,
  input  logic       s_tx_tvalid,
  input  logic       s_tx_tlast,
  input  logic       s_tx_tuser,
  output logic       s_tx_tready,
  output logic [7:0] rgmii_mac_tx_data,
  output logic       rgmii_mac_tx_dv,
  output logic       rgmii_mac_tx_er,
  input  logic       rgmii_mac_tx_rdy,
  output logic       tx_busy,
  output logic       tx_underrun
);
  tx_state_t state, state_n;
  logic [3:0] cnt, cnt_n, hold;
  logic [15:0] bcnt, bcnt_n;
  logic [31:0] crc, crc_n, crc_fold, fcs_sh;
  logic [7:0] fold_byte, byte_n;
  logic last_q, last_n, gig, gig_n, phase, dv_n, er_n, underrun_n, boundary, launch;
  crc32_byte u_crc (.crc_in(crc), .data(fold_byte), .crc_out(crc_fold));
  assign boundary = rgmii_mac_tx_rdy && !phase;
  assign launch = boundary && s_tx_tvalid && (state == ST_IDLE || (state == ST_IFG && cnt == 4'(IFG_BYTES - 1)));
  assign s_tx_tready = state == ST_DROP || (boundary && (state == ST_SFD || (state == ST_PAYLOAD && !last_q)));
  assign fcs_sh = ~crc >> {cnt[1:0] + 2'd1, 3'b000};
  // Every branch below fixes the byte that goes on the wire for the next byte-time.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bcnt_n = bcnt;
    crc_n = crc;
    last_n = last_q;
    gig_n = gig;
    fold_byte = 8'h00;
    byte_n = 8'h00;
    dv_n = 1'b0;
    er_n = 1'b0;
    underrun_n = 1'b0;
    if (state == ST_DROP) begin
      if (s_tx_tvalid && s_tx_tlast) begin
        state_n = ST_IFG;
        cnt_n = '0;
      end
    end else if (launch) begin
      state_n = ST_PREAMBLE;
      cnt_n = '0;
      bcnt_n = '0;
      crc_n = CRC32_INIT;
      last_n = 1'b0;
      gig_n = link_speed == SPEED_1000;
      byte_n = ETH_PREAMBLE;
      dv_n = 1'b1;
    end else if (boundary) begin
      case (state)
        ST_PREAMBLE: begin
          dv_n = 1'b1;
          cnt_n = cnt + 4'd1;
          state_n = cnt == 4'(PREAMBLE_BYTES - 1) ? ST_SFD : ST_PREAMBLE;
          byte_n = cnt == 4'(PREAMBLE_BYTES - 1) ? ETH_SFD : ETH_PREAMBLE;
        end
        ST_SFD, ST_PAYLOAD, ST_PAD: begin
          dv_n = 1'b1;
          if (s_tx_tready) begin
            if (s_tx_tvalid) begin
              byte_n = s_tx_tdata;
              er_n = s_tx_tuser;
              fold_byte = s_tx_tdata;
              crc_n = crc_fold;
              bcnt_n = bcnt + 16'(bcnt != '1);
              last_n = s_tx_tlast;
              state_n = ST_PAYLOAD;
            end else begin
              er_n = 1'b1;
              underrun_n = 1'b1;
              state_n = ST_ERR;
            end
          end else if (bcnt < 16'(MIN_FRAME_BYTES)) begin
            crc_n = crc_fold;
            bcnt_n = bcnt + 16'd1;
            state_n = ST_PAD;
          end else begin
            byte_n = ~crc[7:0];
            cnt_n = '0;
            state_n = ST_FCS;
          end
        end
        ST_FCS: begin
          if (cnt == 4'd3) begin
            state_n = ST_IFG;
            cnt_n = '0;
          end else begin
            dv_n = 1'b1;
            cnt_n = cnt + 4'd1;
            byte_n = fcs_sh[7:0];
          end
        end
        ST_IFG: begin
          state_n = cnt == 4'(IFG_BYTES - 1) ? ST_IDLE : ST_IFG;
          cnt_n = cnt + 4'd1;
        end
        ST_ERR: state_n = ST_DROP;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      bcnt <= '0;
      crc <= CRC32_INIT;
      last_q <= 1'b0;
      gig <= 1'b0;
      phase <= 1'b0;
      hold <= '0;
      rgmii_mac_tx_data <= '0;
      rgmii_mac_tx_dv <= 1'b0;
      rgmii_mac_tx_er <= 1'b0;
      tx_busy <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bcnt <= bcnt_n;
      crc <= crc_n;
      last_q <= last_n;
      gig <= gig_n;
      tx_busy <= state_n != ST_IDLE;
      tx_underrun <= underrun_n;
      if (boundary) begin
        hold <= byte_n[7:4];
        rgmii_mac_tx_dv <= dv_n;
        rgmii_mac_tx_er <= er_n;
        rgmii_mac_tx_data <= gig_n ? byte_n : {2{byte_n[3:0]}};
        phase <= !gig_n && state_n != ST_IDLE;
      end else if (rgmii_mac_tx_rdy) begin
        rgmii_mac_tx_data <= {2{hold}};
        phase <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rgmii_mac_tx.sv
// tb_rgmii_mac_tx: randomized frames checked against a byte-level framing model
module tb_rgmii_mac_tx;
  import eth_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] link_speed = 2'b10;
  logic [7:0] s_tx_tdata = 8'h00;
  logic s_tx_tvalid = 1'b0, s_tx_tlast = 1'b0, s_tx_tuser = 1'b0, s_tx_tready;
  logic [7:0] rgmii_mac_tx_data;
  logic rgmii_mac_tx_dv, rgmii_mac_tx_er, tx_busy, tx_underrun;
  logic rgmii_mac_tx_rdy = 1'b0;

  rgmii_mac_tx dut (
    .clk(clk), .reset(reset), .link_speed(link_speed),
    .s_tx_tdata(s_tx_tdata), .s_tx_tvalid(s_tx_tvalid), .s_tx_tlast(s_tx_tlast),
    .s_tx_tuser(s_tx_tuser), .s_tx_tready(s_tx_tready),
    .rgmii_mac_tx_data(rgmii_mac_tx_data), .rgmii_mac_tx_dv(rgmii_mac_tx_dv),
    .rgmii_mac_tx_er(rgmii_mac_tx_er), .rgmii_mac_tx_rdy(rgmii_mac_tx_rdy),
    .tx_busy(tx_busy), .tx_underrun(tx_underrun)
  );

  always #4 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [9:0] src_q[$];
  logic [7:0] cap_d[$], raw[$], exp_d[$];
  bit cap_e[$], exp_e[$];
  int gap_q[$];
  int rdy_div = 1, ph = 0, frames = 0, gap_steps = 0, underruns = 0, accepts = 0, ready_clks = 0;
  bit in_frame = 0, half = 0, nib_bad = 0;
  logic [3:0] lo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] b);
    for (int k = 0; k < 8; k++) c = (c[0] ^ b[k]) ? (c >> 1) ^ CRC32_POLY_REFL : c >> 1;
    return c;
  endfunction

  // Reassembles wire bytes from output steps; nibble pairs below 1000M.
  task automatic sample();
    bit g = link_speed == 2'b10;
    if (rgmii_mac_tx_dv) begin
      if (!in_frame) begin
        if (frames > 0) gap_q.push_back(g ? gap_steps : gap_steps / 2);
        in_frame = 1;
        half = 0;
        raw.delete();
      end
      raw.push_back(rgmii_mac_tx_data);
      if (g) begin
        cap_d.push_back(rgmii_mac_tx_data);
        cap_e.push_back(rgmii_mac_tx_er);
      end else begin
        if (rgmii_mac_tx_data[7:4] != rgmii_mac_tx_data[3:0]) nib_bad = 1;
        if (!half) begin
          lo = rgmii_mac_tx_data[3:0];
          half = 1;
        end else begin
          cap_d.push_back({rgmii_mac_tx_data[7:4], lo});
          cap_e.push_back(rgmii_mac_tx_er);
          half = 0;
        end
      end
    end else begin
      if (in_frame) begin
        in_frame = 0;
        frames++;
        gap_steps = 0;
      end
      gap_steps++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (tx_underrun) underruns++;
    if (rgmii_mac_tx_rdy && !reset) sample();
    ph++;
    rgmii_mac_tx_rdy = (ph % rdy_div) == 0;
    s_tx_tvalid = src_q.size() > 0 && !reset;
    if (s_tx_tvalid) {s_tx_tuser, s_tx_tlast, s_tx_tdata} = src_q[0];
    else {s_tx_tuser, s_tx_tlast, s_tx_tdata} = 10'h0;
    #1;
    if (s_tx_tready) ready_clks++;
    if (s_tx_tvalid && s_tx_tready) begin
      void'(src_q.pop_front());
      accepts++;
    end
  end

  task automatic clear_all();
    cap_d.delete(); cap_e.delete(); exp_d.delete(); exp_e.delete(); raw.delete(); gap_q.delete();
    frames = 0; gap_steps = 0; underruns = 0; accepts = 0; ready_clks = 0;
    in_frame = 0; half = 0; nib_bad = 0;
  endtask

  task automatic push_exp(input logic [7:0] d, input bit e);
    exp_d.push_back(d);
    exp_e.push_back(e);
  endtask

  // pat: 0 random, 1 incrementing, 2 random with first byte 0xA7
  task automatic add_frame(input int len, input int pat, input int err_idx);
    logic [7:0] pl[$];
    logic [7:0] b;
    logic [31:0] c, fcs;
    for (int i = 0; i < len; i++) begin
      b = pat == 1 ? 8'(i) : (pat == 2 && i == 0) ? 8'hA7 : 8'($urandom);
      pl.push_back(b);
      src_q.push_back({1'(i == err_idx), 1'(i == len - 1), b});
    end
    for (int i = 0; i < 7; i++) push_exp(8'h55, 0);
    push_exp(8'hD5, 0);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < (len > 60 ? len : 60); i++) begin
      b = i < len ? pl[i] : 8'h00;
      push_exp(b, i == err_idx);
      c = crc_upd(c, b);
    end
    fcs = ~c;
    for (int k = 0; k < 4; k++) push_exp(fcs[8*k+:8], 0);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    @(negedge clk);
    while ((tx_busy || src_q.size() > 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_idle"}, 32'(tx_busy || src_q.size() > 0), 32'(0));
  endtask

  task automatic cmp_cap(input string tag);
    check({tag, "_len"}, 32'(cap_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'({cap_e[i], cap_d[i]}), 32'({exp_e[i], exp_d[i]}));
  endtask

  task automatic run(input string tag, input int spd, input int div, input int len, input int pat, input int err_idx);
    clear_all();
    link_speed = 2'(spd);
    rdy_div = div;
    add_frame(len, pat, err_idx);
    wait_idle(tag);
    cmp_cap(tag);
    check({tag, "_frames"}, 32'(frames), 32'(1));
    check({tag, "_accepts"}, 32'(accepts), 32'(len));
    check({tag, "_nibrep"}, 32'(nib_bad), 32'(0));
  endtask

  initial begin
    logic [31:0] c;
    int t, spd, len, err;
    repeat (3) @(negedge clk);
    #2;
    check("rst_dv", 32'(rgmii_mac_tx_dv), 32'(0));
    check("rst_er", 32'(rgmii_mac_tx_er), 32'(0));
    check("rst_data", 32'(rgmii_mac_tx_data), 32'(0));
    check("rst_busy", 32'(tx_busy), 32'(0));
    check("rst_tready", 32'(s_tx_tready), 32'(0));
    check("rst_underrun", 32'(tx_underrun), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    run("t1", 2, 1, 60, 1, -1);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < cap_d.size(); i++) c = crc_upd(c, cap_d[i]);
    check("t1_residue", c, CRC32_RESIDUE);

    run("t2", 2, 1, 10, 0, -1);
    check("t2_tready_clks", 32'(ready_clks), 32'(10));

    run("t3", 1, 5, 20, 2, -1);
    check("t3_pre0", 32'(raw[0]), 32'h55);
    check("t3_sfd_lo", 32'(raw[14]), 32'h55);
    check("t3_sfd_hi", 32'(raw[15]), 32'hDD);
    check("t3_a7_lo", 32'(raw[16]), 32'h77);
    check("t3_a7_hi", 32'(raw[17]), 32'hAA);
    check("t3_tready_clks", 32'(ready_clks), 32'(20));

    clear_all();
    link_speed = 2'b10;
    rdy_div = 1;
    for (int i = 0; i < 7; i++) push_exp(8'h55, 0);
    push_exp(8'hD5, 0);
    for (int i = 0; i < 20; i++) begin
      src_q.push_back({2'b00, 8'(i * 13 + 1)});
      push_exp(8'(i * 13 + 1), 0);
    end
    push_exp(8'h00, 1);
    t = 0;
    while (underruns < 1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("t4_underrun_seen", 32'(underruns), 32'(1));
    for (int i = 0; i < 5; i++) src_q.push_back({1'b0, 1'(i == 4), 8'($urandom)});
    wait_idle("t4");
    cmp_cap("t4");
    check("t4_underruns", 32'(underruns), 32'(1));
    check("t4_frames", 32'(frames), 32'(1));
    check("t4_accepts", 32'(accepts), 32'(25));

    run("t5", 2, 1, 30, 0, 5);
    run("t5_10m", 0, 3, 15, 0, 5);

    clear_all();
    link_speed = 2'b10;
    rdy_div = 1;
    add_frame(25, 0, -1);
    add_frame(70, 0, -1);
    wait_idle("t6b2b");
    cmp_cap("t6b2b");
    check("t6_frames", 32'(frames), 32'(2));
    check("t6_gaps", 32'(gap_q.size()), 32'(1));
    check("t6_gap", 32'(gap_q.size() > 0 ? gap_q[0] : -1), 32'(12));

    clear_all();
    add_frame(40, 0, -1);
    t = 0;
    while (accepts < 10 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("t6_midframe", 32'(accepts >= 10), 32'(1));
    #3 reset = 1'b1;
    #1;
    check("t6_rst_dv", 32'(rgmii_mac_tx_dv), 32'(0));
    check("t6_rst_busy", 32'(tx_busy), 32'(0));
    check("t6_rst_tready", 32'(s_tx_tready), 32'(0));
    src_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run("t6_after", 2, 1, 12, 0, -1);

    for (int r = 0; r < 6; r++) begin
      spd = $urandom_range(0, 2);
      len = $urandom_range(1, 100);
      err = $urandom_range(0, 3) == 0 ? $urandom_range(0, len - 1) : -1;
      run($sformatf("rnd%0d", r), spd, spd == 2 ? 1 : $urandom_range(1, 4), len, 0, err);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
